// File: rtl/mc_decoder.sv
// mc_decoder: multicycle ARM-subset control unit (Moore FSM plus ALU decoder).
// Optional build macro MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until MemReady=1.
module mc_decoder #(
    parameter int ALUCTRL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 MemReady,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 NoWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 WD3Src,
    output logic                 Undef
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRLINK, BRANCH
    } state_e;

    state_e state_q, state_d;

    logic mem_ready;
`ifdef MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ready        = 1'b1;
`endif

    // ALU command decode; the extended commands exist only in the 3-bit build.
    logic       cmd_ok;
    logic       cmd_nowrite;
    logic       cmd_arith;
    logic [2:0] cmd_ctl;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cmd_ok      = 1'b1;
        cmd_nowrite = 1'b0;
        cmd_arith   = 1'b0;
        cmd_ctl     = 3'd0;
        case (Funct[4:1])
            4'b0100: begin cmd_ctl = 3'd0; cmd_arith = 1'b1; end
            4'b0010: begin cmd_ctl = 3'd1; cmd_arith = 1'b1; end
            4'b0000: cmd_ctl = 3'd2;
            4'b1100: cmd_ctl = 3'd3;
            4'b1101: cmd_ctl = 3'd0;
            4'b0001: begin
                if (ALUCTRL_W >= 3) cmd_ctl = 3'd4;
                else                cmd_ok  = 1'b0;
            end
            4'b1010: begin
                if (ALUCTRL_W >= 3) begin
                    cmd_ctl     = 3'd1;
                    cmd_nowrite = 1'b1;
                    cmd_arith   = 1'b1;
                end else begin
                    cmd_ok = 1'b0;
                end
            end
            4'b1000: begin
                if (ALUCTRL_W >= 3) begin
                    cmd_ctl     = 3'd2;
                    cmd_nowrite = 1'b1;
                end else begin
                    cmd_ok = 1'b0;
                end
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    logic instr_undef;
    always_comb begin
        case (Op)
            2'b00:   instr_undef = ~cmd_ok;
            2'b01:   instr_undef = 1'b0;
            2'b10:   instr_undef = ~Funct[5];
            default: instr_undef = 1'b1;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (instr_undef)      state_d = FETCH;
                else if (Op == 2'b00) state_d = Funct[5] ? EXECUTEI : EXECUTER;
                else if (Op == 2'b01) state_d = MEMADR;
                else                  state_d = Funct[4] ? BRLINK : BRANCH;
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECUTER,
            EXECUTEI: state_d = cmd_nowrite ? FETCH : ALUWB;
            ALUWB:    state_d = FETCH;
            BRLINK:   state_d = BRANCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    logic branch;
    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        WD3Src    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTEI: ALUSrcB = 2'b01;
            ALUWB:    RegW    = 1'b1;
            BRLINK: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegW      = 1'b1;
                WD3Src    = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    logic in_exec;
    assign in_exec    = (state_q == EXECUTER) || (state_q == EXECUTEI);
    assign ALUControl = in_exec ? ALUCTRL_W'(cmd_ctl) : '0;
    assign FlagW      = (in_exec && cmd_ok) ? {Funct[0], Funct[0] & cmd_arith} : 2'b00;
    assign NoWrite    = in_exec & cmd_nowrite;
    assign Undef      = (state_q == DECODE) & instr_undef;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign PCS        = ((Rd == 4'd15) & RegW) | branch;

endmodule

// File: tb/tb_mc_decoder.sv
// Self-checking bench for mc_decoder: two instances (ALUCTRL_W 2 and 3) checked per cycle
// against an instruction-level plan model; honours MEM_WAIT_EN when the build defines it.
`timescale 1ns/1ps
module tb_mc_decoder;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] flagw;
        logic       pcs, nextpc, regw, memw, irwrite, nowrite, adrsrc, alusrca;
        logic [1:0] alusrcb, resultsrc, immsrc, regsrc;
        logic [2:0] aluctl;
        logic       wd3src, undef;
    } out_t;

    typedef enum {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
        ST_EXECR, ST_EXECI, ST_ALUWB, ST_BRLINK, ST_BRANCH
    } step_e;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;

    logic [1:0] flagw [2];
    logic       pcs [2], nextpc [2], regw [2], memw [2], irwrite [2], nowrite [2];
    logic       adrsrc [2], alusrca [2], wd3src [2], undef [2];
    logic [1:0] alusrcb [2], resultsrc [2], immsrc [2], regsrc [2];
    logic [1:0] aluc2;
    logic [2:0] aluc3;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cur_w    = 2;
    int    low_left = 0;
    step_e plan [$];

    always #5 clk = ~clk;

    mc_decoder #(.ALUCTRL_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .FlagW(flagw[0]), .PCS(pcs[0]), .NextPC(nextpc[0]), .RegW(regw[0]), .MemW(memw[0]),
        .IRWrite(irwrite[0]), .NoWrite(nowrite[0]), .AdrSrc(adrsrc[0]), .ALUSrcA(alusrca[0]),
        .ALUSrcB(alusrcb[0]), .ResultSrc(resultsrc[0]), .ImmSrc(immsrc[0]), .RegSrc(regsrc[0]),
        .ALUControl(aluc2), .WD3Src(wd3src[0]), .Undef(undef[0])
    );

    mc_decoder #(.ALUCTRL_W(3)) u_dut3 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .FlagW(flagw[1]), .PCS(pcs[1]), .NextPC(nextpc[1]), .RegW(regw[1]), .MemW(memw[1]),
        .IRWrite(irwrite[1]), .NoWrite(nowrite[1]), .AdrSrc(adrsrc[1]), .ALUSrcA(alusrca[1]),
        .ALUSrcB(alusrcb[1]), .ResultSrc(resultsrc[1]), .ImmSrc(immsrc[1]), .RegSrc(regsrc[1]),
        .ALUControl(aluc3), .WD3Src(wd3src[1]), .Undef(undef[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t w=%0d)", tag, got, exp, $time, cur_w);
        end
    endtask

    function automatic out_t observe(input int s);
        out_t o;
        o.flagw = flagw[s];     o.pcs = pcs[s];         o.nextpc = nextpc[s];
        o.regw = regw[s];       o.memw = memw[s];       o.irwrite = irwrite[s];
        o.nowrite = nowrite[s]; o.adrsrc = adrsrc[s];   o.alusrca = alusrca[s];
        o.alusrcb = alusrcb[s]; o.resultsrc = resultsrc[s];
        o.immsrc = immsrc[s];   o.regsrc = regsrc[s];
        o.aluctl = (s == 1) ? aluc3 : {1'b0, aluc2};
        o.wd3src = wd3src[s];   o.undef = undef[s];
        return o;
    endfunction

    // Command table: returns whether the command exists at this width and its ALU behaviour.
    function automatic void alu_ref(input int w, input logic [5:0] f, output bit ok,
                                    output logic [2:0] ctl, output bit nw, output bit arith);
        ok = 1; ctl = 0; nw = 0; arith = 0;
        case (f[4:1])
            4'b0100: begin ctl = 0; arith = 1; end
            4'b0010: begin ctl = 1; arith = 1; end
            4'b0000: ctl = 2;
            4'b1100: ctl = 3;
            4'b1101: ctl = 0;
            4'b0001: if (w == 3) ctl = 4; else ok = 0;
            4'b1010: if (w == 3) begin ctl = 1; nw = 1; arith = 1; end else ok = 0;
            4'b1000: if (w == 3) begin ctl = 2; nw = 1; end else ok = 0;
            default: ok = 0;
        endcase
    endfunction

    function automatic bit undef_ref(input logic [1:0] op, input logic [5:0] f, input int w);
        bit ok, nw, ar;
        logic [2:0] c;
        alu_ref(w, f, ok, c, nw, ar);
        if (op == 2'b00) return !ok;
        if (op == 2'b01) return 0;
        if (op == 2'b10) return !f[5];
        return 1;
    endfunction

    task automatic make_plan(input logic [1:0] op, input logic [5:0] f, input int w);
        bit ok, nw, ar;
        logic [2:0] c;
        alu_ref(w, f, ok, c, nw, ar);
        plan = {ST_FETCH, ST_DECODE};
        if (!undef_ref(op, f, w)) begin
            case (op)
                2'b00: begin
                    plan.push_back(f[5] ? ST_EXECI : ST_EXECR);
                    if (!nw) plan.push_back(ST_ALUWB);
                end
                2'b01: begin
                    plan.push_back(ST_MEMADR);
                    if (f[0]) begin plan.push_back(ST_MEMREAD); plan.push_back(ST_MEMWB); end
                    else      plan.push_back(ST_MEMWRITE);
                end
                default: begin
                    if (f[4]) plan.push_back(ST_BRLINK);
                    plan.push_back(ST_BRANCH);
                end
            endcase
        end
    endtask

    function automatic out_t expect_out(input step_e st, input logic [1:0] op,
                                        input logic [5:0] f, input logic [3:0] rd, input int w);
        out_t e;
        bit ok, nw, ar, br;
        logic [2:0] c;
        alu_ref(w, f, ok, c, nw, ar);
        e = '0;
        br = 0;
        e.immsrc = op;
        e.regsrc = {op == 2'b01, op == 2'b10};
        case (st)
            ST_FETCH:    begin e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; e.irwrite = 1; e.nextpc = 1; end
            ST_DECODE:   begin e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; e.undef = undef_ref(op, f, w); end
            ST_MEMADR:   e.alusrcb = 1;
            ST_MEMREAD:  e.adrsrc = 1;
            ST_MEMWB:    begin e.resultsrc = 1; e.regw = 1; end
            ST_MEMWRITE: begin e.adrsrc = 1; e.memw = 1; end
            ST_EXECR, ST_EXECI: begin
                e.alusrcb = (st == ST_EXECI) ? 2'd1 : 2'd0;
                e.aluctl  = c;
                e.nowrite = nw;
                e.flagw   = {f[0], f[0] & ar};
            end
            ST_ALUWB:    e.regw = 1;
            ST_BRLINK:   begin e.alusrca = 1; e.alusrcb = 2; e.resultsrc = 2; e.regw = 1; e.wd3src = 1; end
            ST_BRANCH:   begin e.alusrcb = 1; e.resultsrc = 2; br = 1; end
            default: ;
        endcase
        e.pcs = ((rd == 4'd15) && e.regw) || br;
        return e;
    endfunction

    // Runs one instruction from FETCH, checking every cycle; abort_idx>=0 fires reset mid-step.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int abort_idx);
        int s;
        s = (cur_w == 3) ? 1 : 0;
        Op = op; Funct = f; Rd = rd;
        make_plan(op, f, cur_w);
        for (int i = 0; i < plan.size(); i++) begin
            int hold = 0;
            forever begin
                if (plan[i] == ST_MEMWRITE && low_left > 0) begin
                    MemReady = 1'b0;
                    low_left--;
                end else begin
                    MemReady = (hold >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                @(negedge clk);
                check(plan[i].name(), {9'd0, observe(s)}, {9'd0, expect_out(plan[i], op, f, rd, cur_w)});
                if (i == abort_idx) begin
                    #1 reset = 1'b1;
                    #1 check("rst_async", {9'd0, observe(s)}, {9'd0, expect_out(ST_FETCH, op, f, rd, cur_w)});
                    @(posedge clk);
                    #1 check("rst_held", {9'd0, observe(s)}, {9'd0, expect_out(ST_FETCH, op, f, rd, cur_w)});
                    reset = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                if (WAIT_EN && !MemReady &&
                    (plan[i] == ST_FETCH || plan[i] == ST_MEMREAD || plan[i] == ST_MEMWRITE))
                    hold++;
                else
                    break;
            end
        end
    endtask

    task automatic start_phase(input int w);
        cur_w = w;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic random_instr();
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] cmds [8];
        int r;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b0001, 4'b1010, 4'b1000};
        r  = $urandom_range(0, 9);
        op = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        f  = 6'($urandom);
        if (op == 2'b00 && $urandom_range(0, 4) != 0) f[4:1] = cmds[$urandom_range(0, 7)];
        if (op == 2'b10 && $urandom_range(0, 3) != 0) f[5] = 1'b1;
        rd = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
        run_instr(op, f, rd, -1);
    endtask

    task automatic directed();
        run_instr(2'b00, 6'b001001, 4'd3, -1);  // ADD reg, S=1
        run_instr(2'b01, 6'b011001, 4'd15, -1); // LDR into PC
        run_instr(2'b10, 6'b110000, 4'd7, -1);  // BL
        run_instr(2'b00, 6'b010101, 4'd0, -1);  // CMP
        run_instr(2'b00, 6'b010001, 4'd1, -1);  // TST
        run_instr(2'b00, 6'b100011, 4'd2, -1);  // EOR imm, S=1
        run_instr(2'b00, 6'b111010, 4'd15, -1); // MOV imm into PC
        run_instr(2'b11, 6'b000000, 4'd0, -1);  // undefined op
        low_left = 3;
        run_instr(2'b01, 6'b011000, 4'd2, -1);  // STR with memory stalled
        low_left = 0;
        run_instr(2'b01, 6'b011001, 4'd4, 3);   // LDR interrupted in MEMREAD
        run_instr(2'b10, 6'b100000, 4'd15, -1); // B after the reset
    endtask

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MemReady = 1'b0;
        @(negedge clk);
        check("reset_w2", {9'd0, observe(0)}, {9'd0, expect_out(ST_FETCH, 2'b00, 6'd0, 4'd0, 2)});
        check("reset_w3", {9'd0, observe(1)}, {9'd0, expect_out(ST_FETCH, 2'b00, 6'd0, 4'd0, 3)});
        for (int w = 2; w <= 3; w++) begin
            start_phase(w);
            directed();
            for (int n = 0; n < 200; n++) random_instr();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
